// File: rtl/regfile_sb.sv
// Parametrised register file with write-back bypass, optional hardwired zero
// register and a per-register pending-write scoreboard for RAW stall detection.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_i,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data_o,
    output logic [RD_PORTS-1:0]          rd_busy_o,
    input  logic                         issue_valid_i,
    input  logic [ADDR_W-1:0]            issue_addr_i,
    output logic                         issue_ready_o,
    input  logic                         wb_valid_i,
    input  logic [ADDR_W-1:0]            wb_addr_i,
    input  logic [DATA_W-1:0]            wb_data_i,
    input  logic                         flush_i,
    output logic                         wb_err_o
);

    localparam int unsigned NREGS   = 1 << ADDR_W;
    localparam int unsigned CNT_W   = $clog2(MAX_PEND + 1);
    localparam bit          ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  cnt  [NREGS];

    logic [NREGS-1:0]  wb_hit_c;
    logic [CNT_W-1:0]  pend_c [NREGS];
    logic              issue_zero_c;
    logic              wb_zero_c;
    logic              issue_acc_c;
    logic              wb_err_next_c;

    // Claims still outstanding once this cycle's write-back retires one.
    always_comb begin
        for (int unsigned a = 0; a < NREGS; a++) begin
            wb_hit_c[a] = wb_valid_i && (wb_addr_i == ADDR_W'(a)) && (cnt[a] != '0);
            pend_c[a]   = cnt[a] - CNT_W'(wb_hit_c[a]);
        end
    end

    // Read ports: zero register first, then same-cycle bypass, then array.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            if (ZERO_EN && (rd_addr_i[p*ADDR_W +: ADDR_W] == '0)) begin
                rd_data_o[p*DATA_W +: DATA_W] = '0;
                rd_busy_o[p]                  = 1'b0;
            end else begin
                if (wb_valid_i && (wb_addr_i == rd_addr_i[p*ADDR_W +: ADDR_W])) begin
                    rd_data_o[p*DATA_W +: DATA_W] = wb_data_i;
                end else begin
                    rd_data_o[p*DATA_W +: DATA_W] = regs[rd_addr_i[p*ADDR_W +: ADDR_W]];
                end
                rd_busy_o[p] = (pend_c[rd_addr_i[p*ADDR_W +: ADDR_W]] != '0);
            end
        end
    end

    // Claim acceptance; a retiring write-back frees a slot in the same cycle.
    always_comb begin
        issue_zero_c  = ZERO_EN && (issue_addr_i == '0);
        wb_zero_c     = ZERO_EN && (wb_addr_i == '0);
        issue_ready_o = issue_zero_c || (pend_c[issue_addr_i] < CNT_W'(MAX_PEND));
        issue_acc_c   = issue_valid_i && issue_ready_o && !flush_i && !issue_zero_c;
        wb_err_next_c = wb_valid_i && (cnt[wb_addr_i] == '0) && !flush_i && !wb_zero_c;
    end

    // Data array: write-back lands regardless of claims or flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned a = 0; a < NREGS; a++) begin
                regs[a] <= '0;
            end
        end else if (wb_valid_i && !wb_zero_c) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Scoreboard counters; flush discards every outstanding claim.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int unsigned a = 0; a < NREGS; a++) begin
                cnt[a] <= '0;
            end
        end else begin
            for (int unsigned a = 0; a < NREGS; a++) begin
                cnt[a] <= cnt[a]
                          + CNT_W'(issue_acc_c && (issue_addr_i == ADDR_W'(a)))
                          - CNT_W'(wb_hit_c[a]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_err_o <= 1'b0;
        end else begin
            wb_err_o <= wb_err_next_c;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized
// traffic checked against a behavioural scoreboard model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_valid;
    logic [2:0]  issue_addr;
    logic        issue_ready;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic        wb_err;

    int checks   = 0;
    int failures = 0;

    // Model state: register contents, outstanding-claim counts, error flag.
    logic [15:0] m_regs [8];
    int          m_cnt  [8];
    logic        m_err;

    regfile_sb dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .issue_valid_i(issue_valid),
        .issue_addr_i (issue_addr),
        .issue_ready_o(issue_ready),
        .wb_valid_i   (wb_valid),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .flush_i      (flush),
        .wb_err_o     (wb_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_hit(int a);
        return wb_valid && (int'(wb_addr) == a) && (m_cnt[a] != 0);
    endfunction

    function automatic logic [15:0] m_rd(int a);
        if (a == 0) return 16'h0;
        if (wb_valid && int'(wb_addr) == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(int a);
        if (a == 0) return 1'b0;
        return (m_cnt[a] - int'(m_hit(a))) != 0;
    endfunction

    function automatic logic m_ready();
        int a = int'(issue_addr);
        if (a == 0) return 1'b1;
        return (m_cnt[a] - int'(m_hit(a))) < 3;
    endfunction

    task automatic idle();
        rst = 0; issue_valid = 0; issue_addr = 0; wb_valid = 0;
        wb_addr = 0; wb_data = 0; flush = 0;
    endtask

    task automatic set_rd(int a0, int a1);
        rd_addr = {3'(a1), 3'(a0)};
    endtask

    // Advance one clock: the model consumes the current inputs at the edge,
    // then outputs are sampled on the falling edge.
    task automatic cycle();
        logic [15:0] n_regs [8];
        int          n_cnt  [8];
        logic        n_err;
        bit          acc;
        n_regs = m_regs;
        n_cnt  = m_cnt;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin n_regs[i] = 0; n_cnt[i] = 0; end
            n_err = 0;
        end else begin
            if (wb_valid && wb_addr != 0) n_regs[wb_addr] = wb_data;
            n_err = wb_valid && m_cnt[wb_addr] == 0 && !flush && wb_addr != 0;
            acc   = issue_valid && m_ready() && !flush && issue_addr != 0;
            if (flush) begin
                for (int i = 0; i < 8; i++) n_cnt[i] = 0;
            end else begin
                if (acc) n_cnt[issue_addr] = n_cnt[issue_addr] + 1;
                if (m_hit(int'(wb_addr))) n_cnt[wb_addr] = n_cnt[wb_addr] - 1;
            end
        end
        @(posedge clk);
        m_regs = n_regs;
        m_cnt  = n_cnt;
        m_err  = n_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        set_rd(0, 0);
        rst = 1;
        issue_valid = 1; issue_addr = 3; wb_valid = 1; wb_addr = 2; wb_data = 16'hDEAD;
        cycle();
        idle();
        #1;
        for (int a = 0; a < 8; a++) begin
            set_rd(a, 7 - a);
            issue_addr = 3'(a);
            #1;
            checks++;
            if (rd_data !== 32'h0 || rd_busy !== 2'b00) begin
                failures++;
                $display("FAIL reset_read addr=%0d data=%h busy=%b required data=0 busy=0", a, rd_data, rd_busy);
            end
            checks++;
            if (issue_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready addr=%0d got=%b required=1", a, issue_ready);
            end
        end
        checks++;
        if (wb_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b required=0", wb_err);
        end
    endtask

    task automatic test_claim_wb();
        idle();
        set_rd(3, 3);
        issue_valid = 1; issue_addr = 3;
        cycle();
        idle();
        for (int c = 2; c <= 3; c++) begin
            #1;
            checks++;
            if (rd_busy !== 2'b11) begin
                failures++;
                $display("FAIL claim_busy cycle=%0d got=%b required=11", c, rd_busy);
            end
            cycle();
        end
        wb_valid = 1; wb_addr = 3; wb_data = 16'h1234;
        #1;
        checks++;
        if (rd_busy !== 2'b00 || rd_data !== 32'h1234_1234) begin
            failures++;
            $display("FAIL claim_bypass busy=%b data=%h required busy=00 data=12341234", rd_busy, rd_data);
        end
        cycle();
        idle();
        #1;
        checks++;
        if (rd_data !== 32'h1234_1234 || rd_busy !== 2'b00 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL claim_array data=%h busy=%b err=%b required data=12341234 busy=00 err=0",
                     rd_data, rd_busy, wb_err);
        end
    endtask

    task automatic test_saturate();
        idle();
        set_rd(5, 0);
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_addr = 5;
            cycle();
        end
        idle();
        issue_addr = 5;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL sat_full_ready got=%b required=0", issue_ready);
        end
        issue_valid = 1; wb_valid = 1; wb_addr = 5; wb_data = 16'h0A0A;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL sat_issue_with_wb ready=%b required=1", issue_ready);
        end
        cycle();
        idle();
        issue_addr = 5;
        #1;
        checks++;
        if (issue_ready !== 1'b0 || rd_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL sat_still_full ready=%b busy=%b required ready=0 busy=1", issue_ready, rd_busy[0]);
        end
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1; wb_addr = 5; wb_data = 16'(16'h0B00 + i);
            #1;
            checks++;
            if (rd_busy[0] !== (i < 2 ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL sat_retire wb=%0d busy=%b required=%b", i, rd_busy[0], (i < 2));
            end
            cycle();
        end
        idle();
        #1;
        checks++;
        if (wb_err !== 1'b0 || rd_data[15:0] !== 16'h0B02) begin
            failures++;
            $display("FAIL sat_final err=%b data=%h required err=0 data=0b02", wb_err, rd_data[15:0]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        set_rd(0, 0);
        wb_valid = 1; wb_addr = 0; wb_data = 16'hFFFF;
        issue_valid = 1; issue_addr = 0;
        #1;
        checks++;
        if (rd_data !== 32'h0 || rd_busy !== 2'b00 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_same_cycle data=%h busy=%b ready=%b required 0/00/1", rd_data, rd_busy, issue_ready);
        end
        cycle();
        idle();
        wb_valid = 1; wb_addr = 0; wb_data = 16'h7777;
        #1;
        checks++;
        if (rd_data !== 32'h0 || rd_busy !== 2'b00 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_after data=%h busy=%b err=%b required 0/00/0", rd_data, rd_busy, wb_err);
        end
        cycle();
        idle();
        #1;
        checks++;
        if (wb_err !== 1'b0 || rd_data !== 32'h0) begin
            failures++;
            $display("FAIL zero_no_err err=%b data=%h required err=0 data=0", wb_err, rd_data);
        end
    endtask

    task automatic test_flush();
        idle();
        issue_valid = 1; issue_addr = 2;
        cycle();
        issue_addr = 6;
        cycle();
        idle();
        flush = 1; issue_valid = 1; issue_addr = 1;
        wb_valid = 1; wb_addr = 2; wb_data = 16'h00AA;
        cycle();
        idle();
        set_rd(1, 2);
        #1;
        checks++;
        if (rd_busy !== 2'b00 || rd_data[31:16] !== 16'h00AA || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_r1r2 busy=%b r2=%h err=%b required busy=00 r2=00aa err=0",
                     rd_busy, rd_data[31:16], wb_err);
        end
        set_rd(6, 6);
        #1;
        checks++;
        if (rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL flush_r6 busy=%b required=00", rd_busy);
        end
        wb_valid = 1; wb_addr = 6; wb_data = 16'h0BEE;
        cycle();
        idle();
        #1;
        checks++;
        if (wb_err !== 1'b1 || rd_data[15:0] !== 16'h0BEE) begin
            failures++;
            $display("FAIL flush_late_wb err=%b r6=%h required err=1 r6=0bee", wb_err, rd_data[15:0]);
        end
        cycle();
        checks++;
        if (wb_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_err_pulse err=%b required=0", wb_err);
        end
    endtask

    task automatic test_mid_reset();
        idle();
        wb_valid = 1; wb_addr = 4; wb_data = 16'h5555;
        cycle();
        idle();
        issue_valid = 1; issue_addr = 4;
        cycle();
        idle();
        set_rd(4, 4);
        rst = 1; issue_valid = 1; issue_addr = 4; wb_valid = 1; wb_addr = 1; wb_data = 16'h1111;
        cycle();
        idle();
        #1;
        checks++;
        if (rd_data !== 32'h0 || rd_busy !== 2'b00 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset data=%h busy=%b err=%b required 0/00/0", rd_data, rd_busy, wb_err);
        end
    endtask

    task automatic test_random();
        int a0, a1;
        for (int n = 0; n < 600; n++) begin
            idle();
            rst         = ($urandom_range(199) == 0);
            flush       = ($urandom_range(29) == 0);
            issue_valid = ($urandom_range(9) < 5);
            issue_addr  = 3'($urandom_range(7));
            wb_valid    = ($urandom_range(9) < 5);
            wb_addr     = 3'($urandom_range(7));
            wb_data     = 16'($urandom);
            a0 = $urandom_range(7);
            a1 = ($urandom_range(3) == 0) ? int'(wb_addr) : $urandom_range(7);
            set_rd(a0, a1);
            #1;
            checks++;
            if (rd_data !== {m_rd(a1), m_rd(a0)} || rd_busy !== {m_busy(a1), m_busy(a0)}) begin
                failures++;
                $display("FAIL rand_read n=%0d data=%h busy=%b required data=%h busy=%b",
                         n, rd_data, rd_busy, {m_rd(a1), m_rd(a0)}, {m_busy(a1), m_busy(a0)});
            end
            checks++;
            if (issue_ready !== m_ready() || wb_err !== m_err) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d ready=%b err=%b required ready=%b err=%b",
                         n, issue_ready, wb_err, m_ready(), m_err);
            end
            cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
        m_err = 0;
        idle();
        set_rd(0, 0);
        @(negedge clk);
        test_reset();
        test_claim_wb();
        test_saturate();
        test_zero_reg();
        test_flush();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
